// File: rtl/linebuffer_scaler_if.sv
// Video bus between the core output and the line buffer / scaler path.
// Master drives the input video stream and receives the centred output line.
interface linebuffer_scaler_if #(
    parameter int DATA_WIDTH = 24,
    parameter int AW         = 10
);
    logic                  vsync_in;
    logic                  hsync_in;
    logic                  ce_pix;
    logic                  disable_pix;
    logic [DATA_WIDTH-1:0] rgb_in;
    logic                  vsync_out;
    logic                  hsync_out;
    logic                  de;
    logic [DATA_WIDTH-1:0] rgb_out;
    logic [AW:0]           line_width;
    logic                  overflow;

    modport master (
        output vsync_in, hsync_in, ce_pix, disable_pix, rgb_in,
        input  vsync_out, hsync_out, de, rgb_out, line_width, overflow
    );

    modport slave (
        input  vsync_in, hsync_in, ce_pix, disable_pix, rgb_in,
        output vsync_out, hsync_out, de, rgb_out, line_width, overflow
    );
endinterface

// File: rtl/linebuffer_scaler.sv
// Ping-pong line buffer: captures one line while replaying the previous one,
// horizontally centred (padded or centre-cropped) into an OUT_WIDTH window.
// Optional feature macro: LINEBUFFER_BORDER_EN -- when defined, padding pixels
// are shown as BORDER_RGB with de=1; otherwise padding is blank (de=0).
// HS_DELAY must be at least 1.
module linebuffer_scaler #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    DEPTH      = 1024,
    parameter int                    AW         = $clog2(DEPTH),
    parameter int                    OUT_WIDTH  = 512,
    parameter int                    HS_DELAY   = 15,
    parameter int                    HS_OFFSET  = 6,
    parameter logic [DATA_WIDTH-1:0] BORDER_RGB = '0
) (
    input  logic               clk_vid,
    input  logic               reset_n,
    linebuffer_scaler_if.slave vid
);
    localparam int            AW1     = AW + 1;
    localparam int            DW      = $clog2(HS_DELAY + 2);
    localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);
    localparam logic [AW:0]   OW      = AW1'(OUT_WIDTH);
`ifdef LINEBUFFER_BORDER_EN
    localparam bit            SHOW_PAD = 1'b1;
`else
    localparam bit            SHOW_PAD = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DELAY, LPAD, ACTIVE, RPAD} state_t;

    // Both banks live in one array; the MSB of the address is the bank.
    logic [DATA_WIDTH-1:0] mem [2*DEPTH];

    state_t                state;
    logic                  hs_prev, vs_prev, bank_sel;
    logic [AW:0]           wr_cnt, line_width, cnt;
    logic [AW-1:0]         rd_addr;
    logic [DW-1:0]         dly;
    logic                  overflow, vsync_out, hsync_out, de;
    logic [DATA_WIDTH-1:0] rgb_out, rd_q;

    logic h_edge, v_edge, strobe, wr_en;
    assign h_edge = vid.hsync_in & ~hs_prev;
    assign v_edge = vid.vsync_in & ~vs_prev;
    assign strobe = vid.ce_pix & ~vid.disable_pix;
    assign wr_en  = strobe & (wr_cnt != DEPTH_W);
    assign rd_q   = mem[{bank_sel, rd_addr}];

    assign vid.vsync_out  = vsync_out;
    assign vid.hsync_out  = hsync_out;
    assign vid.de         = de;
    assign vid.rgb_out    = rgb_out;
    assign vid.line_width = line_width;
    assign vid.overflow   = overflow;

    // Line geometry; line_width only changes on an hsync edge, which restarts
    // the replay, so these stay valid for the whole replayed line.
    logic [AW:0]   pad_c, n_c, rpad_c;
    logic [AW-1:0] skip_c;
    always_comb begin
        pad_c  = '0;
        skip_c = '0;
        n_c    = line_width;
        if (line_width <= OW) begin
            pad_c = (OW - line_width) >> 1;
        end else begin
            skip_c = AW'((line_width - OW) >> 1);
            n_c    = OW;
        end
        rpad_c = OW - pad_c - n_c;
    end

    // Capture into the write bank (the one not being replayed).
    always_ff @(posedge clk_vid) begin
        if (wr_en) mem[{~bank_sel, wr_cnt[AW-1:0]}] <= vid.rgb_in;
    end

    // Edge detect, write counter, bank swap, width latch and overflow flag.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev    <= 1'b0;
            vs_prev    <= 1'b0;
            vsync_out  <= 1'b0;
            bank_sel   <= 1'b0;
            wr_cnt     <= '0;
            line_width <= '0;
            overflow   <= 1'b0;
        end else begin
            hs_prev   <= vid.hsync_in;
            vs_prev   <= vid.vsync_in;
            vsync_out <= v_edge;
            if (h_edge) begin
                // a pixel landing in the edge cycle belongs to the closing line
                bank_sel   <= ~bank_sel;
                line_width <= wr_cnt + AW1'(wr_en);
                wr_cnt     <= '0;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + AW1'(1);
            end
            if (v_edge) overflow <= 1'b0;
            if (strobe && wr_cnt == DEPTH_W) overflow <= 1'b1;
        end
    end

    // Replay FSM with registered video outputs; the RAM read in a state's
    // cycle appears on rgb_out one cycle later together with de.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dly       <= '0;
            cnt       <= '0;
            rd_addr   <= '0;
            de        <= 1'b0;
            rgb_out   <= '0;
            hsync_out <= 1'b0;
        end else begin
            hsync_out <= h_edge ? (HS_OFFSET == HS_DELAY)
                                : (state == DELAY && dly == DW'(HS_OFFSET + 1));
            if (h_edge) begin
                de      <= 1'b0;
                rgb_out <= '0;
            end else if (state == ACTIVE) begin
                de      <= 1'b1;
                rgb_out <= rd_q;
            end else if (SHOW_PAD && (state == LPAD || state == RPAD)) begin
                de      <= 1'b1;
                rgb_out <= BORDER_RGB;
            end else begin
                de      <= 1'b0;
                rgb_out <= '0;
            end

            if (h_edge) begin
                state <= DELAY;
                dly   <= DW'(HS_DELAY);
            end else begin
                case (state)
                    DELAY: begin
                        dly <= dly - DW'(1);
                        if (dly == DW'(1)) begin
                            if (pad_c != '0) begin
                                state <= LPAD;   cnt <= pad_c;
                            end else if (n_c != '0) begin
                                state <= ACTIVE; cnt <= n_c; rd_addr <= skip_c;
                            end else if (rpad_c != '0) begin
                                state <= RPAD;   cnt <= rpad_c;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    LPAD: begin
                        cnt <= cnt - AW1'(1);
                        if (cnt == AW1'(1)) begin
                            if (n_c != '0) begin
                                state <= ACTIVE; cnt <= n_c; rd_addr <= skip_c;
                            end else if (rpad_c != '0) begin
                                state <= RPAD;   cnt <= rpad_c;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ACTIVE: begin
                        cnt     <= cnt - AW1'(1);
                        rd_addr <= rd_addr + AW'(1);
                        if (cnt == AW1'(1)) begin
                            if (rpad_c != '0) begin
                                state <= RPAD; cnt <= rpad_c;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    RPAD: begin
                        cnt <= cnt - AW1'(1);
                        if (cnt == AW1'(1)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_linebuffer_scaler.sv
// Directed bench for linebuffer_scaler at default geometry (DEPTH 1024,
// OUT_WIDTH 512, HS_DELAY 15, HS_OFFSET 6): hsync_out lands in cycle 10 and
// the output window starts in cycle 17 after the hsync edge.
module tb_linebuffer_scaler;
    localparam int          DW     = 24;
    localparam int          AW     = 10;
    localparam int          D0     = 17;
    localparam int          HS_CYC = 10;
    localparam logic [23:0] BORDER = 24'h102030;

    logic clk_vid = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_vid = ~clk_vid;

    linebuffer_scaler_if #(.DATA_WIDTH(DW), .AW(AW)) vif ();

    linebuffer_scaler #(.BORDER_RGB(BORDER)) dut (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .vid     (vif)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int npix;     // valid pixels of the line (ramp 0..npix-1)
        bit dis;      // interleave disabled strobes carrying junk
        bit wr_on_e;  // last pixel written in the hsync edge cycle
        int exp_w;
        bit exp_ovf;
        int pad;
        int n;
        int skip;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic write_line(input int npix, input int base, input bit dis);
        for (int i = 0; i < npix; i++) begin
            if (dis && (i % 50) == 25) begin
                vif.ce_pix = 1'b1; vif.disable_pix = 1'b1; vif.rgb_in = 24'hABCDEF;
                step();
                vif.disable_pix = 1'b0;
            end
            vif.ce_pix = 1'b1;
            vif.rgb_in = 24'(base + i);
            step();
        end
        vif.ce_pix = 1'b0;
    endtask

    // Raise hsync in the current cycle (cycle 0) and watch 560 cycles of output.
    task automatic observe(input string tag, input int exp_w, input bit exp_ovf,
                           input int pad, input int n, input int skip, input int base,
                           input bit e_write, input int e_val);
        int  hs_first, hs_cnt, errs, bad_c, w_got;
        bit  ovf_got, exp_de, in_data, in_win;
        logic [23:0] exp_rgb;
        logic        bad_de;
        logic [23:0] bad_rgb, bad_exp;
        bit          bad_exp_de;
        hs_first = -1; hs_cnt = 0; errs = 0; bad_c = -1; w_got = -1; ovf_got = 1'b0;
        bad_de = 1'b0; bad_rgb = '0; bad_exp = '0; bad_exp_de = 1'b0;
        vif.hsync_in = 1'b1;
        if (e_write) begin
            vif.ce_pix = 1'b1;
            vif.rgb_in = 24'(e_val);
        end
        for (int c = 0; c < 560; c++) begin
            @(negedge clk_vid);
            if (vif.hsync_out) begin
                if (hs_first < 0) hs_first = c;
                hs_cnt++;
            end
            if (c == 1) begin
                w_got   = int'(vif.line_width);
                ovf_got = vif.overflow;
            end
            if (c >= 1) begin
                in_data = (c >= D0 + pad) && (c < D0 + pad + n);
                in_win  = (c >= D0) && (c < D0 + 512);
`ifdef LINEBUFFER_BORDER_EN
                exp_de  = in_win;
                exp_rgb = in_data ? 24'(base + skip + c - D0 - pad) : (in_win ? BORDER : 24'h0);
`else
                exp_de  = in_data;
                exp_rgb = in_data ? 24'(base + skip + c - D0 - pad) : 24'h0;
`endif
                if (vif.de !== exp_de || vif.rgb_out !== exp_rgb) begin
                    if (errs == 0) begin
                        bad_c = c; bad_de = vif.de; bad_rgb = vif.rgb_out;
                        bad_exp_de = exp_de; bad_exp = exp_rgb;
                    end
                    errs++;
                end
            end
            step();
            if (c == 0) begin
                vif.hsync_in = 1'b0;
                vif.ce_pix   = 1'b0;
            end
        end
        chk({tag, ".hsync_cycle"}, hs_first, HS_CYC);
        chk({tag, ".hsync_count"}, hs_cnt, 1);
        chk({tag, ".line_width"}, w_got, exp_w);
        chk({tag, ".overflow"}, ovf_got, exp_ovf);
        if (errs != 0)
            $display("  %s first bad cycle %0d: de=%0b rgb=%h, want de=%0b rgb=%h",
                     tag, bad_c, bad_de, bad_rgb, bad_exp_de, bad_exp);
        chk({tag, ".video_errs"}, errs, 0);
    endtask

    initial begin
        int          errs, pat;
        bit          ovf0, ovf1;
        tbl[0] = '{320,  1'b0, 1'b0, 320,  1'b0, 96,  320, 0};
        tbl[1] = '{600,  1'b1, 1'b0, 600,  1'b0, 0,   512, 44};
        tbl[2] = '{0,    1'b0, 1'b0, 0,    1'b0, 256, 0,   0};
        tbl[3] = '{512,  1'b0, 1'b0, 512,  1'b0, 0,   512, 0};
        tbl[4] = '{513,  1'b0, 1'b1, 513,  1'b0, 0,   512, 0};
        tbl[5] = '{1024, 1'b0, 1'b0, 1024, 1'b0, 0,   512, 256};
        tbl[6] = '{1100, 1'b0, 1'b0, 1024, 1'b1, 0,   512, 256};

        vif.vsync_in = 1'b0; vif.hsync_in = 1'b0; vif.ce_pix = 1'b0;
        vif.disable_pix = 1'b0; vif.rgb_in = '0;
        step(); step(); step();
        @(negedge clk_vid);
        chk("reset.de", vif.de, 0);
        chk("reset.rgb_out", vif.rgb_out, 0);
        chk("reset.hsync_out", vif.hsync_out, 0);
        chk("reset.vsync_out", vif.vsync_out, 0);
        chk("reset.line_width", vif.line_width, 0);
        chk("reset.overflow", vif.overflow, 0);
        @(posedge clk_vid); #1;
        reset_n = 1'b1;
        step(); step();

        // Table of full lines: write, hsync edge, check replay.
        for (int t = 0; t < 7; t++) begin
            write_line(tbl[t].npix - int'(tbl[t].wr_on_e), 0, tbl[t].dis);
            observe($sformatf("line%0d", t), tbl[t].exp_w, tbl[t].exp_ovf, tbl[t].pad,
                    tbl[t].n, tbl[t].skip, 0, tbl[t].wr_on_e, tbl[t].npix - 1);
        end

        // V edge: one-cycle vsync_out pulse even with vsync held, clears overflow.
        pat = 0; ovf0 = 1'b0; ovf1 = 1'b1;
        vif.vsync_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_vid);
            if (vif.vsync_out) pat |= (1 << c);
            if (c == 0) ovf0 = vif.overflow;
            if (c == 1) ovf1 = vif.overflow;
            step();
        end
        vif.vsync_in = 1'b0;
        chk("vsync.pulse_pattern", pat, 2);
        chk("vsync.overflow_before", ovf0, 1);
        chk("vsync.overflow_after", ovf1, 0);
        step();

        // Second hsync edge 50 cycles into ACTIVE of a 320-pixel line.
        write_line(320, 0, 1'b0);
        vif.hsync_in = 1'b1;
        step();
        vif.hsync_in = 1'b0;
        errs = 0;
        for (int c = 1; c < 162; c++) begin
            vif.ce_pix = (c >= 2 && c < 152);
            vif.rgb_in = 24'(5000 + c - 2);
            @(negedge clk_vid);
            if (c >= 113 && (vif.de !== 1'b1 || vif.rgb_out !== 24'(c - 113))) errs++;
            step();
        end
        vif.ce_pix = 1'b0;
        chk("abort.pre_pixels_errs", errs, 0);
        observe("abort", 150, 1'b0, 181, 150, 0, 5000, 1'b0, 0);

        // Asynchronous reset in the middle of ACTIVE of an overflowed line.
        write_line(1100, 0, 1'b0);
        vif.hsync_in = 1'b1;
        step();
        vif.hsync_in = 1'b0;
        for (int c = 1; c < 150; c++) begin
            if (c == 149) begin
                @(negedge clk_vid);
                chk("rst.pre_de", vif.de, 1);
                chk("rst.pre_overflow", vif.overflow, 1);
                chk("rst.pre_line_width", vif.line_width, 1024);
            end
            step();
        end
        reset_n = 1'b0;
        #1;
        chk("rst.de", vif.de, 0);
        chk("rst.rgb_out", vif.rgb_out, 0);
        chk("rst.hsync_out", vif.hsync_out, 0);
        chk("rst.line_width", vif.line_width, 0);
        chk("rst.overflow", vif.overflow, 0);
        #2;
        reset_n = 1'b1;
        step(); step();
        observe("post_reset", 0, 1'b0, 256, 0, 0, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/linebuffer_scaler.md
# linebuffer_scaler

Parametrised ping-pong line buffer between the core video output and the scaler/APF video path in the `clk_vid` domain. It captures one input line while replaying the previous one at one pixel per clock, with programmable hsync delay. Each replayed line is horizontally centred into a fixed output window: it is padded when shorter than the window and centre-cropped when longer. It reports the measured line width and a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 24, pixel width in bits.
- `DEPTH`, 1024, pixels per bank; must be a power of 2.
- `AW`, `$clog2(DEPTH)`, address width; derived, do not override.
- `OUT_WIDTH`, 512, output window in pixels; must satisfy 1 ≤ `OUT_WIDTH` ≤ `DEPTH`.
- `HS_DELAY`, 15, cycles from the input hsync edge to the start of the output line.
- `HS_OFFSET`, 6, position of the `hsync_out` pulse within the delay; must satisfy `HS_OFFSET` ≤ `HS_DELAY`.
- `BORDER_RGB`, 0, colour of padding pixels (used only when `LINEBUFFER_BORDER_EN` is defined).

Ports:
- `clk_vid`, in, 1: video clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `vsync_in`, in, 1: input vsync, level.
- `hsync_in`, in, 1: input hsync, level.
- `ce_pix`, in, 1: input pixel strobe.
- `disable_pix`, in, 1: blanks the current pixel; no write occurs.
- `rgb_in`, in, `DATA_WIDTH`: input pixel.
- `vsync_out`, out, 1: one-cycle pulse.
- `hsync_out`, out, 1: one-cycle pulse.
- `de`, out, 1: output data enable, registered.
- `rgb_out`, out, `DATA_WIDTH`: output pixel, registered; 0 whenever `de`=0.
- `line_width`, out, `AW+1`: width of the line currently being replayed.
- `overflow`, out, 1: sticky; set when a line exceeds `DEPTH`.

## Operation
- Two simple dual-port RAM banks, `DEPTH`×`DATA_WIDTH`. `bank_sel` chooses the read bank; the other bank is the write bank.
- Edge detection uses a registered previous value. H edge E: `hsync_in & ~hs_prev`. V edge: `vsync_in & ~vs_prev`.
- Write side:
  - On `ce_pix & ~disable_pix`, write to the write bank at `wr_cnt`, then increment.
  - When `wr_cnt`=`DEPTH`, further writes are dropped and `overflow` is set.
- At E:
  - Toggle `bank_sel`.
  - Latch `line_width` ← `wr_cnt`, then clear `wr_cnt`.
  - A write in the same cycle as E goes to the closing bank and is counted in its width.
- Read FSM: IDLE → DELAY → LPAD → ACTIVE → RPAD → IDLE.
  - E in any state, including mid-line: abort, then enter DELAY with `dly`=`HS_DELAY`.
  - DELAY: decrement `dly`. At `dly`=0, compute:
    - w = `line_width`.
    - If w ≤ `OUT_WIDTH`: pad=(`OUT_WIDTH`−w)>>1, skip=0, n=w.
    - Else: pad=0, skip=(w−`OUT_WIDTH`)>>1, n=`OUT_WIDTH`.
  - LPAD: pad cycles.
  - ACTIVE: n cycles, reading addresses skip … skip+n−1.
  - RPAD: `OUT_WIDTH`−pad−n cycles, then IDLE.
  - w=0: ACTIVE is skipped.
- `vsync_out` pulses the cycle after the V edge. The V edge also clears `overflow`.
- Reset clears the FSM to IDLE, `bank_sel`, `wr_cnt`, `line_width`, `overflow`, `de`, `rgb_out`, `hsync_out`, `vsync_out`, and the edge registers, all to 0. RAM contents are don't-care.

## Timing
- E occurs in cycle 0.
- `hsync_out` is high in cycle 1+`HS_DELAY`−`HS_OFFSET` only. Default: cycle 10.
- The LPAD or ACTIVE phase begins in cycle 1+`HS_DELAY`.
- RAM read latency is 1 cycle. The first `de`=1 pixel (non-border build) appears in cycle 2+`HS_DELAY`+pad.
- `de` is high for n consecutive cycles.
- The `line_width` update is visible in cycle 1.
- A pixel written in cycle k is readable from cycle k+1.

## Configuration
- `LINEBUFFER_BORDER_EN` defined:
  - `de`=1 for all `OUT_WIDTH` cycles of LPAD, ACTIVE and RPAD, starting at cycle 2+`HS_DELAY`.
  - `rgb_out`=`BORDER_RGB` in LPAD and RPAD.
- Undefined: `de`=1 only for the n ACTIVE pixels. RPAD still elapses but outputs nothing.

## Test plan
- 320 ramp pixels (value=index), then E, with defaults: `hsync_out` at cycle 10; `de` high cycles 113–432; `rgb_out` 0…319; `line_width`=320.
- 600 pixels then E: pad=0, skip=44; 512 `de` cycles from cycle 17; first pixel 44, last pixel 555.
- 1100 pixels then E: `line_width`=1024, `overflow`=1 until the next V edge; then `overflow`=0 and `vsync_out` is a one-cycle pulse.
- Second E 50 cycles into ACTIVE: output aborts (`de`=0) and the new line replays with the new bank and width; no stale pixels appear.
- `reset_n` low mid-ACTIVE: `de`, `rgb_out`, `hsync_out`, `line_width` and `overflow` go to 0 immediately; after release, the first E replays a width-0 line with no `de`.
- With `LINEBUFFER_BORDER_EN` and `BORDER_RGB`=24'h102030, 320-pixel line: `de` high for 512 cycles from cycle 17; cycles 17–112 and 433–528 output 24'h102030.
